// File: rtl/regwb_ctrl.sv
// -----------------------------------------------------------------------------
// regwb_ctrl: register-file writeback controller.
//
// Merges two writeback sources into a single registered register-bank write
// port. It also keeps a pending-write scoreboard, and can optionally provide
// bypass (forwarding) hits from the registered write port.
//
// Sources:
//   - ALU writebacks are unbuffered. The ALU is accepted only in a cycle
//     where it wins arbitration.
//   - Load-unit (LSU) writebacks pass through a 2-entry FIFO.
//   - The FIFO head normally has priority. When the ALU has lost three
//     consecutive cycles, it is given the slot.
//
// Ports:
//   i_clk, i_rstn                      clock, async active-low reset
//   i_alu_valid/o_alu_ready            ALU writeback handshake
//   i_alu_rd[4:0], i_alu_data[31:0]    ALU destination / result
//   i_lsu_valid/o_lsu_ready            load writeback handshake (into FIFO)
//   i_lsu_rd[4:0], i_lsu_data[31:0]    load destination / data
//   i_iss_valid/o_iss_ready            issue-stage destination reservation
//   i_iss_rd[4:0]                      register being reserved
//   o_busy[31:1]                       scoreboard, bit i = write to xi pending
//   o_wr_strb[31:1], o_wr_data[31:0]   registered register-bank write port
//   i_fwd_addr_a/b[4:0]                bypass compare addresses
//   o_fwd_a_hit/data, o_fwd_b_hit/data bypass results
//
// Configuration:
//   REGWB_FWD_EN   defined  : bypass outputs compare against the write port.
//                  undefined: bypass outputs are tied to zero.
// -----------------------------------------------------------------------------
module regwb_ctrl (
   input  logic        i_clk,
   input  logic        i_rstn,
   // ALU writeback
   input  logic        i_alu_valid,
   output logic        o_alu_ready,
   input  logic [4:0]  i_alu_rd,
   input  logic [31:0] i_alu_data,
   // load-unit writeback
   input  logic        i_lsu_valid,
   output logic        o_lsu_ready,
   input  logic [4:0]  i_lsu_rd,
   input  logic [31:0] i_lsu_data,
   // issue reservation
   input  logic        i_iss_valid,
   output logic        o_iss_ready,
   input  logic [4:0]  i_iss_rd,
   // scoreboard and register-bank write port
   output logic [31:1] o_busy,
   output logic [31:1] o_wr_strb,
   output logic [31:0] o_wr_data,
   // bypass
   input  logic [4:0]  i_fwd_addr_a,
   input  logic [4:0]  i_fwd_addr_b,
   output logic        o_fwd_a_hit,
   output logic [31:0] o_fwd_a_data,
   output logic        o_fwd_b_hit,
   output logic [31:0] o_fwd_b_data
);

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [4:0]  fifo_rd_q   [2];
   logic [31:0] fifo_data_q [2];
   logic        rd_ptr_q, wr_ptr_q;
   logic [1:0]  count_q, count_d;

   logic [1:0]  starve_q, starve_d;
   logic [31:1] busy_q, busy_d;
   logic [31:1] wr_strb_q, wr_strb_d;
   logic [31:0] wr_data_q, wr_data_d;

   // --------------------------------------------------------------------------
   // Arbitration and handshakes
   // --------------------------------------------------------------------------
   logic        fifo_empty, fifo_full;
   logic        alu_win, alu_xfer;
   logic        lsu_push, lsu_pop;
   logic        iss_xfer;
   logic        win_valid;
   logic [4:0]  win_rd;
   logic [31:0] win_data;
   logic [31:0] busy_ext;

   assign fifo_empty = (count_q == 2'd0);
   assign fifo_full  = (count_q == 2'd2);

   // The ALU owns the write slot when there is nothing queued, or when it is
   // starved. Both terms are registered, so the ready signal does not depend
   // on valid.
   assign alu_win     = fifo_empty | (starve_q == 2'd3);
   assign o_alu_ready = alu_win;
   assign alu_xfer    = i_alu_valid & alu_win;

   // The FIFO head drains whenever the ALU is not actually taking the slot.
   assign lsu_pop     = ~fifo_empty & ~alu_xfer;

   // Readiness comes from the registered fill level only. A push is refused
   // while full, even when a pop happens in the same cycle.
   assign o_lsu_ready = ~fifo_full;
   assign lsu_push    = i_lsu_valid & ~fifo_full;

   // Bit 0 of the extended vector is always clear, so x0 never blocks issue.
   assign busy_ext    = {busy_q, 1'b0};
   assign o_iss_ready = ~busy_ext[i_iss_rd];
   assign iss_xfer    = i_iss_valid & o_iss_ready;

   always_comb begin
      win_valid = 1'b0;
      win_rd    = 5'd0;
      win_data  = 32'd0;
      if (lsu_pop) begin
         win_valid = 1'b1;
         win_rd    = fifo_rd_q[rd_ptr_q];
         win_data  = fifo_data_q[rd_ptr_q];
      end else if (alu_xfer) begin
         win_valid = 1'b1;
         win_rd    = i_alu_rd;
         win_data  = i_alu_data;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      wr_strb_d = '0;
      busy_d    = '0;
      for (int i = 1; i < 32; i++) begin
         // A winner with rd = 0 completes its handshake but strobes nothing.
         wr_strb_d[i] = win_valid & (win_rd == 5'(i));
         // The scoreboard clears on the strobe edge. A new reservation at the
         // same edge takes precedence.
         busy_d[i]    = (busy_q[i] & ~wr_strb_d[i]) | (iss_xfer & (i_iss_rd == 5'(i)));
      end
   end

   assign wr_data_d = win_valid ? win_data : wr_data_q;

   always_comb begin
      starve_d = 2'd0;
      if (i_alu_valid && !alu_xfer) begin
         starve_d = (starve_q == 2'd3) ? 2'd3 : starve_q + 2'd1;
      end
   end

   always_comb begin
      case ({lsu_push, lsu_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 0; i < 2; i++) begin
            fifo_rd_q[i]   <= 5'd0;
            fifo_data_q[i] <= 32'd0;
         end
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         starve_q  <= 2'd0;
         busy_q    <= '0;
         wr_strb_q <= '0;
         wr_data_q <= 32'd0;
      end else begin
         if (lsu_push) begin
            fifo_rd_q[wr_ptr_q]   <= i_lsu_rd;
            fifo_data_q[wr_ptr_q] <= i_lsu_data;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (lsu_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q   <= count_d;
         starve_q  <= starve_d;
         busy_q    <= busy_d;
         wr_strb_q <= wr_strb_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign o_busy    = busy_q;
   assign o_wr_strb = wr_strb_q;
   assign o_wr_data = wr_data_q;

   // --------------------------------------------------------------------------
   // Bypass
   // --------------------------------------------------------------------------
`ifdef REGWB_FWD_EN
   logic [31:0] strb_ext;

   // Bit 0 is always clear, so address 0 can never hit.
   assign strb_ext     = {wr_strb_q, 1'b0};
   assign o_fwd_a_hit  = strb_ext[i_fwd_addr_a];
   assign o_fwd_b_hit  = strb_ext[i_fwd_addr_b];
   assign o_fwd_a_data = wr_data_q;
   assign o_fwd_b_data = wr_data_q;
`else
   logic unused_fwd;

   assign unused_fwd   = ^{i_fwd_addr_a, i_fwd_addr_b};
   assign o_fwd_a_hit  = 1'b0;
   assign o_fwd_b_hit  = 1'b0;
   assign o_fwd_a_data = 32'd0;
   assign o_fwd_b_data = 32'd0;
`endif

endmodule
